// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the accumulator ALU: queues commands, issues one per cycle, returns reported results.
// Results appear two cycles after issue; report issue is throttled by result-FIFO credits.

module seq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign dout    = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end
endmodule

module alu_cmd_sequencer #(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [15:0] cmd_operand,
   input  logic        cmd_report,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_operand,
   input  logic [31:0] alu_result,
   input  logic        alu_carry,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_carry,
   output logic        err_illegal,
   output logic        idle
);
   localparam int CW = $clog2(RES_DEPTH + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(RES_DEPTH);

   typedef struct packed {
      logic        report;
      logic [3:0]  opcode;
      logic [15:0] operand;
   } cmd_t;

   cmd_t          cmd_in;
   cmd_t          head;
   logic          cmd_full;
   logic          cmd_empty;
   logic          cmd_push;
   logic          cmd_pop;
   logic          head_illegal;
   logic          issue_rpt;
   logic [CW-1:0] credits;
   logic          rpt_d1;
   logic          rpt_d2;
   logic          issued_plain;
   logic          res_full;
   logic          res_empty;
   logic          res_pop;
   logic [32:0]   res_head;

   assign cmd_in    = '{report: cmd_report, opcode: cmd_opcode, operand: cmd_operand};
   assign cmd_ready = !cmd_full;
   assign cmd_push  = cmd_valid && cmd_ready;

   seq_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (cmd_push),
      .din   (cmd_in),
      .pop   (cmd_pop),
      .dout  (head),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   // An illegal head never produces a result, so it may drain even when credits are exhausted.
   assign head_illegal = (head.opcode > 4'd12);
   assign cmd_pop      = !cmd_empty && (!head.report || head_illegal || (credits < CREDIT_MAX));
   assign issue_rpt    = cmd_pop && head.report && !head_illegal;
   assign res_pop      = res_valid && res_ready;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         alu_opcode   <= '0;
         alu_operand  <= '0;
         err_illegal  <= 1'b0;
         credits      <= '0;
         rpt_d1       <= 1'b0;
         rpt_d2       <= 1'b0;
         issued_plain <= 1'b0;
      end else begin
         if (cmd_pop && !head_illegal) begin
            alu_opcode  <= head.opcode;
            alu_operand <= head.operand;
         end else begin
            alu_opcode  <= '0;
            alu_operand <= '0;
         end
         if (cmd_pop && head_illegal) err_illegal <= 1'b1;
         credits      <= credits + {{(CW-1){1'b0}}, issue_rpt} - {{(CW-1){1'b0}}, res_pop};
         rpt_d1       <= issue_rpt;
         rpt_d2       <= rpt_d1;
         issued_plain <= cmd_pop && !head.report && !head_illegal;
      end
   end

   // rpt_d2 lines up with the accumulator value produced by the reported command.
   seq_fifo #(.WIDTH(33), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (rpt_d2),
      .din   ({alu_carry, alu_result}),
      .pop   (res_pop),
      .dout  (res_head),
      .full  (res_full),
      .empty (res_empty)
   );

   assign res_valid            = !res_empty;
   assign {res_carry, res_data} = res_head;
   assign idle = cmd_empty && !rpt_d1 && !rpt_d2 && !issued_plain;

   always @(posedge clk) begin
      if (rstb) assert (!(rpt_d2 && res_full));
   end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the behavioural accumulator ALU (b_ALU).
- Accepts {report, opcode, operand} commands over a valid/ready handshake and buffers them in a command FIFO.
- Issues at most one command per cycle on registered opcode/operand outputs, and holds the accumulator with NOP when nothing is issued.
- For commands flagged "report", captures the resulting 32-bit accumulator value and carry, and returns them on a result valid/ready handshake.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- RES_DEPTH, 2, result FIFO entries (power of 2, ≥2); also the report-credit limit.

Ports:
- clk  input  1  clock.
- rstb  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command FIFO not full.
- cmd_opcode  input  4  ALU opcode.
- cmd_operand  input  16  operand for dp_input.
- cmd_report  input  1  return the result of this command.
- alu_opcode  output  4  to ALU opcode; registered.
- alu_operand  output  16  to ALU dp_input; registered.
- alu_result  input  32  from ALU dp_output.
- alu_carry  input  1  from ALU status_out.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed.
- res_data  output  32  accumulator value after the reported command.
- res_carry  output  1  carry/borrow status after the reported command.
- err_illegal  output  1  sticky; set when an illegal opcode was dropped.
- idle  output  1  command FIFO empty and nothing in flight.

Behaviour:
- Reset is rstb, asynchronous, active-low; clock is clk. Reset values:
  - alu_opcode=0 (hold), alu_operand=0.
  - Both FIFOs empty, so cmd_ready=1 and res_valid=0.
  - res_data=0, res_carry=0, err_illegal=0, idle=1.
  - Credit counter 0, pipeline flags 0.
- Opcode map: 0 hold, 1 clear, 2 all-ones, 3 div, 4 sub, 5 sbc, 6 add, 7 adc, 8 mul, 9 and, 10 or, 11 not, 12 xor. Opcodes 13-15 are illegal.
- Command accept: a command is accepted when cmd_valid && cmd_ready on a clk edge. cmd_ready is driven from FIFO occupancy only; it is not combinationally dependent on cmd_valid.
- Issue rule: at each edge the FIFO head is popped and issued when both hold:
  - the FIFO is non-empty;
  - head.report==0, or credits < RES_DEPTH.
  Otherwise alu_opcode<=0 and alu_operand<=0 (NOP).
- Illegal opcode at head: the entry is popped and issued as NOP, err_illegal<=1, and no result is generated even if report=1. It does not consume a credit.
- Credits: count reported commands that are in flight or held in the result FIFO.
  - +1 when a report command issues.
  - −1 on a result pop (res_valid && res_ready).
  - Both on the same edge: net 0.
  - The count never exceeds RES_DEPTH.
- Timing, for a command issued at edge k (outputs valid from k):
  - The ALU accumulator and status update at edge k+1.
  - The sequencer samples alu_result and alu_carry at edge k+2 and pushes them into the result FIFO.
  - The report flag travels through a 2-stage flag pipeline (rpt_d1, rpt_d2).
  - Latency from issue to res_valid is 2 cycles. Back-to-back issue is allowed at 1 command/cycle.
- Result FIFO:
  - res_data and res_carry show the FIFO head.
  - The credit rule guarantees no overflow; a push into a full FIFO is a design error (assertion).
  - Simultaneous push and pop at full or empty must work; with RES_DEPTH≥2 there is no bypass.
- Full/empty: at full, cmd_ready=0; push and pop on the same edge at full is not possible because ready is low. At empty, NOP is issued.
- idle = command FIFO empty && rpt_d1==0 && rpt_d2==0 && no non-report command issued at the last edge.
- Reset mid-operation discards everything: FIFOs, in-flight flags and credits. ALU state is reset by the same rstb.
- Carry semantics: res_carry is status_out after the command executed. For opcodes outside 4-7 it is the unchanged previous status.

Test Plan:
- Push (6, 5, report=0), (6, 3, report=1) back-to-back from reset → alu_opcode 6/6 on consecutive cycles; res_valid 2 cycles after the second issue with res_data=0x00000008, res_carry=0.
- Push (2, 0, 0) then (6, 1, 1) → res_data=0x00000000, res_carry=1. Then push (7, 0, 1) → res_data=0x00000001, res_carry=0.
- Push (1, 0, 0), (6, 0x1234, 0), (8, 0x0010, 1) → res_data=0x00012340.
- Hold res_ready=0 and push 4 report commands → exactly 2 issue; NOPs follow; cmd_ready drops when the command FIFO fills. Release res_ready → the remaining commands issue, and the 4 results come out in order.
- Push opcode 14 with report=1 → issued as NOP, err_illegal=1 and stays 1, no result produced, credits unchanged.
- Assert rstb low with 2 commands queued and 1 report in flight → all outputs return to reset values at once, and no stale result appears after release.
